// File: rtl/mips_data_mem_ctrl.sv
// Byte-addressed MIPS data memory: word/half/byte loads and stores, selectable endianness,
// registered loads, misalignment trapping with a saturating error count, and a post-reset clear sweep.
module mips_data_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int BIG_ENDIAN  = 0,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    mem_address,
  input  logic [31:0]          write_data,
  input  logic                 sig_mem_read,
  input  logic                 sig_mem_write,
  input  logic [1:0]           s,
  input  logic                 sig_mem_unsigned,
  output logic [31:0]          read_data,
  output logic                 read_valid,
  output logic                 busy,
  output logic                 align_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Request handshake: sig_mem_read / sig_mem_write are single-cycle requests sampled at
  // posedge while busy is low; an accepted load answers with read_valid one cycle later,
  // a rejected (illegal) access answers with align_err instead. Requests seen while busy
  // are dropped without any response.

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      init_ptr_q;
  logic [31:0]           mem [DEPTH_WORDS];

  logic [IDX_W-1:0]      idx;
  logic [1:0]            byte_lane;
  logic                  half_sel;
  logic                  legal;
  logic                  req_any;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shifted;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [31:0]           load_val;
  logic [31:0]           wmask;
  logic [31:0]           wdata_lanes;
  logic [31:0]           wr_merged;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [31:0]           mem_wdata;
  logic                  accept_rd;
  logic                  err_pulse;

  logic                  unused_addr;

  assign idx         = mem_address[IDX_W+1:2];
  assign unused_addr = ^{mem_address[ADDR_W-1:IDX_W+2], mem_address[1:0]};
  assign req_any     = sig_mem_read | sig_mem_write;
  assign busy        = (state_q == ST_INIT);

  // Big-endian mirrors the lane index within the word: byte k sits in lane 3-k, half h in 1-h.
  assign byte_lane = (BIG_ENDIAN != 0) ? ~mem_address[1:0] : mem_address[1:0];
  assign half_sel  = (BIG_ENDIAN != 0) ? ~mem_address[1]   : mem_address[1];

  always_comb begin
    legal = 1'b0;
    case (s)
      2'b00:   legal = (mem_address[1:0] == 2'b00);
      2'b01:   legal = ~mem_address[0];
      2'b10:   legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign rd_word    = mem[idx];
  assign rd_shifted = rd_word >> {byte_lane, 3'b000};
  assign byte_val   = rd_shifted[7:0];
  assign half_val   = half_sel ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    case (s)
      2'b01:   load_val = {{16{~sig_mem_unsigned & half_val[15]}}, half_val};
      2'b10:   load_val = {{24{~sig_mem_unsigned & byte_val[7]}}, byte_val};
      default: load_val = rd_word;
    endcase
  end

  // Sub-word stores replicate the data into every lane and let the mask pick the target lanes.
  always_comb begin
    wmask       = 32'h0000_0000;
    wdata_lanes = write_data;
    case (s)
      2'b00: begin
        wmask       = 32'hFFFF_FFFF;
        wdata_lanes = write_data;
      end
      2'b01: begin
        wmask       = half_sel ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata_lanes = {2{write_data[15:0]}};
      end
      2'b10: begin
        wmask       = 32'h0000_00FF << {byte_lane, 3'b000};
        wdata_lanes = {4{write_data[7:0]}};
      end
      default: begin
        wmask       = 32'h0000_0000;
        wdata_lanes = write_data;
      end
    endcase
  end

  assign wr_merged = (rd_word & ~wmask) | (wdata_lanes & wmask);

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = wr_merged;
    accept_rd = 1'b0;
    err_pulse = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_ptr_q;
        mem_wdata = 32'h0000_0000;
        if (init_ptr_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A store beats a simultaneous load; legality applies to the pair as one access.
        if (req_any && !legal) begin
          err_pulse = 1'b1;
        end else if (sig_mem_write) begin
          mem_we = 1'b1;
        end else if (sig_mem_read) begin
          accept_rd = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      read_data  <= 32'h0000_0000;
      read_valid <= 1'b0;
      align_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      read_valid <= accept_rd;
      align_err  <= err_pulse;
      if (state_q == ST_INIT) begin
        init_ptr_q <= init_ptr_q + 1'b1;
      end
      if (accept_rd) begin
        read_data <= load_val;
      end
      if (err_pulse && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  // The array has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mips_data_mem_ctrl.sv
// Directed bench for mips_data_mem_ctrl: stimulus pushes expected load data and error counts
// into queues; a negedge monitor pops and compares whenever read_valid or align_err fires.
module tb_mips_data_mem_ctrl;

  localparam int BE = 0;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] write_data = '0;
  logic        sig_mem_read = 1'b0;
  logic        sig_mem_write = 1'b0;
  logic [1:0]  s = 2'b00;
  logic        sig_mem_unsigned = 1'b0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        busy;
  logic        align_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  mips_data_mem_ctrl #(
    .ADDR_W(32), .DEPTH_WORDS(256), .BIG_ENDIAN(BE), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .write_data(write_data),
    .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write), .s(s),
    .sig_mem_unsigned(sig_mem_unsigned), .read_data(read_data), .read_valid(read_valid),
    .busy(busy), .align_err(align_err), .err_count(err_count)
  );

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] err_q[$];
  logic [31:0] last_exp = '0;
  int          exp_cnt = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (read_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_read_valid: got read_data %h with no load pending", read_data);
        end else begin
          last_exp = exp_q.pop_front();
          chk("load_data", read_data, last_exp);
        end
      end
      if (align_err) begin
        chk("err_no_valid", {31'd0, read_valid}, 32'd0);
        chk("err_read_hold", read_data, last_exp);
        if (err_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_align_err: got err_count %0d with no error pending", err_count);
        end else begin
          chk("err_count", {24'd0, err_count}, err_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic uns);
    sig_mem_read = rd; sig_mem_write = wr; mem_address = a;
    write_data = d; s = sz; sig_mem_unsigned = uns;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] sz, input logic uns);
    @(negedge clk);
    drive(rd, wr, a, d, sz, uns);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    req(1'b0, 1'b1, a, d, sz, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                      input logic [31:0] exp);
    req(1'b1, 1'b0, a, 32'd0, sz, uns);
    exp_q.push_back(exp);
  endtask

  task automatic bad_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [1:0] sz);
    req(rd, wr, a, 32'hFFFF_FFFF, sz, 1'b0);
    exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
    err_q.push_back(32'(exp_cnt));
  endtask

  task automatic assert_reset(input string tag);
    idle(3);
    chk({tag, "_drain_loads"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_drain_errs"}, 32'(err_q.size()), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_read_data"}, read_data, 32'd0);
    chk({tag, "_read_valid"}, {31'd0, read_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_align_err"}, {31'd0, align_err}, 32'd0);
    chk({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
    last_exp = '0;
    exp_cnt = 0;
  endtask

  // Releases reset on a negedge and counts cycles with busy high; optionally issues
  // requests mid-sweep, which the DUT must ignore.
  task automatic release_and_sweep(input string tag, input bit inject);
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      if (inject && n == 50)      drive(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 2'b00, 1'b0);
      else if (inject && n == 51) drive(1'b1, 1'b0, 32'h10, 32'd0, 2'b00, 1'b0);
      else if (inject && n == 52) drive(1'b1, 1'b0, 32'h02, 32'd0, 2'b00, 1'b0);
      else                        drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    chk({tag, "_busy_cycles"}, 32'(n), 32'd256);
  endtask

  initial begin
    #1;
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_read_valid", {31'd0, read_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    repeat (2) @(negedge clk);
    release_and_sweep("sweep0", 1'b0);

    load(32'h40, 2'b00, 1'b0, 32'h0000_0000);
    store(32'h10, 32'h1234_5678, 2'b00);
    store(32'h11, 32'hFFFF_FFAB, 2'b10);
    load(32'h10, 2'b00, 1'b0, (BE != 0) ? 32'h12AB_5678 : 32'h1234_AB78);
    load(32'h11, 2'b10, 1'b0, 32'hFFFF_FFAB);
    load(32'h11, 2'b10, 1'b1, 32'h0000_00AB);
    load(32'h12, 2'b01, 1'b0, (BE != 0) ? 32'h0000_5678 : 32'h0000_1234);
    store(32'h12, 32'h0000_8001, 2'b01);
    load(32'h12, 2'b01, 1'b0, 32'hFFFF_8001);
    load(32'h12, 2'b01, 1'b1, 32'h0000_8001);
    load(32'h10, 2'b00, 1'b0, (BE != 0) ? 32'h12AB_8001 : 32'h8001_AB78);

    bad_access(1'b1, 1'b0, 32'h02, 2'b00);
    bad_access(1'b0, 1'b1, 32'h20, 2'b11);
    bad_access(1'b1, 1'b0, 32'h13, 2'b01);
    load(32'h20, 2'b00, 1'b0, 32'h0000_0000);

    store(32'h400, 32'hDEAD_BEEF, 2'b00);
    load(32'h000, 2'b00, 1'b0, 32'hDEAD_BEEF);
    req(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 2'b00, 1'b0);
    idle(1);
    load(32'h20, 2'b00, 1'b0, 32'hCAFE_F00D);
    load(32'h0F, 2'b10, 1'b1, 32'h0000_0000);

    for (int i = 0; i < 300; i++) begin
      bad_access(i[0], ~i[0], 32'h21, (i[0] ? 2'b00 : 2'b11));
    end
    idle(2);
    chk("err_saturated", {24'd0, err_count}, 32'd255);

    assert_reset("midop");
    release_and_sweep("sweep1_partial", 1'b0);
    load(32'h10, 2'b00, 1'b0, 32'h0000_0000);
    idle(2);
    assert_reset("postsweep");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("midsweep_busy", {31'd0, busy}, 32'd1);
    assert_reset("midsweep");
    release_and_sweep("sweep2", 1'b1);
    load(32'h10, 2'b00, 1'b0, 32'h0000_0000);
    load(32'h00, 2'b00, 1'b0, 32'h0000_0000);
    idle(3);
    chk("final_loads_pending", 32'(exp_q.size()), 32'd0);
    chk("final_errs_pending", 32'(err_q.size()), 32'd0);
    chk("final_err_count", {24'd0, err_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
